// File: rtl/conv_input_interface.sv
// conv_input_interface: loads image rows into a KERNEL_SIZE-row line buffer and streams sliding-window taps to the PE array.
module conv_input_interface #(
  parameter int KERNEL_SIZE = 3,
  parameter int ARRAY_SIZE  = 6,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         enable,
  input  logic [1:0]                                   input_interface_cmd,
  output logic [1:0]                                   input_interface_ack,
  output logic                                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                        mem_addr,
  input  logic [DATA_WIDTH-1:0]                        mem_rd_data,
  output logic                                         window_valid,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]             window_data,
  output logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0]   kernel_pos
);
  localparam int IMAGE_SIZE = ARRAY_SIZE + KERNEL_SIZE - 1;
  localparam int TAPS = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CW = $clog2(IMAGE_SIZE);
  localparam int BW = $clog2(TAPS);
  localparam int RW = $clog2(KERNEL_SIZE);
  typedef enum logic [1:0] {IDLE, LOAD_RD, LOAD_WAIT, SHIFT} state_t;
  state_t state;
  logic [CW-1:0] img_row, col, cap_col, nc;
  logic [RW-1:0] nr;
  logic [BW-1:0] beat, nb;
  logic rd_d;
  logic [DATA_WIDTH-1:0] lbuf [KERNEL_SIZE][IMAGE_SIZE];
  logic [DATA_WIDTH-1:0] staging [IMAGE_SIZE];
  logic [DATA_WIDTH-1:0] next_row [IMAGE_SIZE];
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] nwin;
  // next_row merges the pixel returning this cycle so the final rotate sees the complete row
  always_comb begin
    next_row = staging;
    if (rd_d) next_row[cap_col] = mem_rd_data;
    nb = (state == SHIFT && beat != BW'(TAPS - 1)) ? beat + 1'b1 : '0;
    nr = RW'(int'(nb) / KERNEL_SIZE);
    nc = CW'(int'(nb) % KERNEL_SIZE);
    nwin = '0;
    for (int i = 0; i < ARRAY_SIZE; i++)
      nwin[i*DATA_WIDTH +: DATA_WIDTH] = lbuf[nr][nc + CW'(i)];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      input_interface_ack <= 2'b00;
      mem_rd_en <= 1'b0;
      mem_addr <= '0;
      window_valid <= 1'b0;
      window_data <= '0;
      kernel_pos <= '0;
      img_row <= '0;
      col <= '0;
      cap_col <= '0;
      beat <= '0;
      rd_d <= 1'b0;
      for (int k = 0; k < KERNEL_SIZE; k++)
        for (int j = 0; j < IMAGE_SIZE; j++) lbuf[k][j] <= '0;
      for (int j = 0; j < IMAGE_SIZE; j++) staging[j] <= '0;
    end else if (!enable) begin
      state <= IDLE;
      input_interface_ack <= 2'b00;
      mem_rd_en <= 1'b0;
      window_valid <= 1'b0;
      img_row <= '0;
      rd_d <= 1'b0;
    end else begin
      input_interface_ack <= 2'b00;
      rd_d <= mem_rd_en;
      cap_col <= col;
      if (rd_d) staging <= next_row;
      case (state)
        IDLE: begin
          if (input_interface_cmd == 2'b01) begin
            state <= LOAD_RD;
            mem_rd_en <= 1'b1;
            col <= '0;
            mem_addr <= ADDR_WIDTH'(int'(img_row) * IMAGE_SIZE);
          end else if (input_interface_cmd == 2'b10) begin
            state <= SHIFT;
            window_valid <= 1'b1;
            beat <= '0;
            kernel_pos <= '0;
            window_data <= nwin;
          end
        end
        LOAD_RD: begin
          if (col == CW'(IMAGE_SIZE - 1)) begin
            mem_rd_en <= 1'b0;
            state <= LOAD_WAIT;
          end else begin
            col <= col + 1'b1;
            mem_addr <= ADDR_WIDTH'(int'(img_row) * IMAGE_SIZE + int'(col) + 1);
          end
        end
        LOAD_WAIT: begin
          for (int k = 0; k < KERNEL_SIZE - 1; k++) lbuf[k] <= lbuf[k+1];
          lbuf[KERNEL_SIZE-1] <= next_row;
          input_interface_ack <= 2'b01;
          img_row <= (img_row == CW'(IMAGE_SIZE - 1)) ? '0 : img_row + 1'b1;
          state <= IDLE;
        end
        SHIFT: begin
          if (beat == BW'(TAPS - 1)) begin
            window_valid <= 1'b0;
            input_interface_ack <= 2'b10;
            state <= IDLE;
          end else begin
            beat <= nb;
            kernel_pos <= nb;
            window_data <= nwin;
          end
        end
      endcase
    end
  end
endmodule
